fetch_unit: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the control unit.
- Owns the program counter and fetches 32-bit LEGv8 instructions from instruction memory over a req/ack handshake.
- Presents the instruction and its 11-bit opcode field for decode, and updates the PC from the control unit's pcSrc decision and the sign-extended branch offset.
- Sequential multi-cycle fetch with a stall input for downstream back-pressure.

---
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit.sv | 157 +++++++++++++++
 tb/tb_fetch_unit.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and instruction memory.
// The master side (fetch unit) drives the request and address, and the slave side
// (memory model or real memory) answers with an acknowledge and the instruction word.
interface fetch_unit_if #(
   parameter int PC_W = 64
);

   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_ack;
   logic [31:0]     imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );

endinterface

// File: rtl/fetch_unit.sv
// LEGv8 instruction-fetch stage.
// Owns the program counter, fetches one 32-bit instruction at a time over the imem
// req/ack bus, holds it for decode until the downstream stage accepts it (stall low),
// then advances the PC by 4 or by the word-scaled branch offset chosen by pc_src.
// Throughput is at most one instruction every two cycles (FETCH + ISSUE).
//
// Optional feature, macro FETCH_TIMEOUT_EN:
//   when defined, a FETCH that waits TIMEOUT_CYC cycles without imem_ack moves the
//   unit into an absorbing ERR state and sets the sticky fetch_err flag; only rst
//   leaves ERR. When undefined, FETCH waits forever and fetch_err is tied to 0.
module fetch_unit #(
   parameter int              PC_W        = 64,
   parameter logic [PC_W-1:0] RESET_PC    = '0,
   parameter int              TIMEOUT_CYC = 16
) (
   input  logic               clk,
   input  logic               rst,
   fetch_unit_if.master       imem,
   input  logic               stall,
   input  logic               pc_src,
   input  logic [PC_W-1:0]    branch_off,
   output logic [31:0]        instr,
   output logic [10:0]        opcode,
   output logic [PC_W-1:0]    pc,
   output logic               instr_valid,
   output logic [31:0]        retired,
   output logic               fetch_err
);

   // Reject parameter values that would break PC alignment or the timeout counter.
   if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
      $error("fetch_unit: RESET_PC must be word aligned");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("fetch_unit: TIMEOUT_CYC must be at least 1");
   end

`ifdef FETCH_TIMEOUT_EN
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      ISSUE = 2'd2,
      ERR   = 2'd3
   } state_t;

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] wait_cnt;
   logic             err_q;
`else
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      ISSUE = 2'd2
   } state_t;
`endif

   state_t          state;
   logic [PC_W-1:0] pc_q;
   logic [31:0]     instr_q;
   logic            valid_q;
   logic            req_q;
   logic [31:0]     retired_q;
   logic [PC_W-1:0] pc_seq;
   logic [PC_W-1:0] pc_branch;

   // Candidate next PCs; the shift drops the top two offset bits and every sum
   // wraps modulo 2^PC_W, so bits [1:0] stay zero whenever the PC is aligned.
   assign pc_seq    = pc_q + PC_W'(4);
   assign pc_branch = pc_q + (branch_off << 2);

   // Fetch sequencer: IDLE -> FETCH (wait for ack) -> ISSUE (hold until accepted) -> FETCH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         pc_q      <= RESET_PC;
         instr_q   <= '0;
         valid_q   <= 1'b0;
         req_q     <= 1'b0;
         retired_q <= '0;
`ifdef FETCH_TIMEOUT_EN
         wait_cnt  <= '0;
         err_q     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               state   <= FETCH;
               req_q   <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
               wait_cnt <= '0;
`endif
            end

            FETCH: begin
               if (imem.imem_ack) begin
                  instr_q <= imem.imem_rdata;
                  valid_q <= 1'b1;
                  req_q   <= 1'b0;
                  state   <= ISSUE;
               end
`ifdef FETCH_TIMEOUT_EN
               else if (wait_cnt == LAST_WAIT) begin
                  err_q   <= 1'b1;
                  req_q   <= 1'b0;
                  valid_q <= 1'b0;
                  state   <= ERR;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
            end

            ISSUE: begin
               if (!stall) begin
                  pc_q      <= pc_src ? pc_branch : pc_seq;
                  retired_q <= retired_q + 32'd1;
                  valid_q   <= 1'b0;
                  req_q     <= 1'b1;
                  state     <= FETCH;
`ifdef FETCH_TIMEOUT_EN
                  wait_cnt  <= '0;
`endif
               end
            end

`ifdef FETCH_TIMEOUT_EN
            ERR: begin
               state <= ERR;
            end
`endif

            default: begin
               state <= IDLE;
               req_q <= 1'b0;
            end
         endcase
      end
   end

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = pc_q;

   assign instr       = instr_q;
   assign opcode      = instr_q[31:21];
   assign pc          = pc_q;
   assign instr_valid = valid_q;
   assign retired     = retired_q;

`ifdef FETCH_TIMEOUT_EN
   assign fetch_err = err_q;
`else
   assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: reset, sequential fetch with wait states,
// branches, stall hold, PC wrap, mid-fetch reset, and (when enabled) fetch timeout.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall;
   logic        pc_src;
   logic [63:0] branch_off;
   logic [31:0] instr;
   logic [10:0] opcode;
   logic [63:0] pc;
   logic        instr_valid;
   logic [31:0] retired;
   logic        fetch_err;

   int checks = 0;
   int errors = 0;

   fetch_unit_if #(.PC_W(64)) mem_if ();

   fetch_unit #(
      .PC_W(64),
      .RESET_PC(64'h0),
      .TIMEOUT_CYC(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .imem(mem_if),
      .stall(stall),
      .pc_src(pc_src),
      .branch_off(branch_off),
      .instr(instr),
      .opcode(opcode),
      .pc(pc),
      .instr_valid(instr_valid),
      .retired(retired),
      .fetch_err(fetch_err)
   );

   // 10 ns clock.
   always #5 clk = ~clk;

   // Hard stop in case the sequence ever runs away.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Advance to 1 ns after the next rising edge; all driving and sampling happens there.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset, release, and leave the DUT in its first FETCH cycle with stall held high.
   task automatic start_fetch();
      rst = 1'b1;
      mem_if.imem_ack = 1'b0;
      mem_if.imem_rdata = '0;
      stall = 1'b1;
      pc_src = 1'b0;
      branch_off = '0;
      tick();
      rst = 1'b0;
      tick();
   endtask

   // From FETCH: ack with word, then release ISSUE once with the given branch decision.
   task automatic issue_with(input logic src, input logic [63:0] off, input logic [31:0] word);
      mem_if.imem_ack = 1'b1;
      mem_if.imem_rdata = word;
      tick();
      mem_if.imem_ack = 1'b0;
      pc_src = src;
      branch_off = off;
      stall = 1'b0;
      tick();
      stall = 1'b1;
      pc_src = 1'b0;
      branch_off = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      stall = 1'b1;
      pc_src = 1'b0;
      branch_off = '0;
      mem_if.imem_ack = 1'b0;
      mem_if.imem_rdata = '0;
      tick();
      tick();
      checks++; if (mem_if.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_req got %0h exp 0", mem_if.imem_req); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid got %0h exp 0", instr_valid); end
      checks++; if (pc !== 64'h0) begin errors++; $display("[TB] FAIL rst_pc got %0h exp 0", pc); end
      checks++; if (instr !== 32'h0) begin errors++; $display("[TB] FAIL rst_instr got %0h exp 0", instr); end
      checks++; if (retired !== 32'h0) begin errors++; $display("[TB] FAIL rst_retired got %0h exp 0", retired); end
      checks++; if (fetch_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_err got %0h exp 0", fetch_err); end
      rst = 1'b0;
      tick();
      checks++; if (mem_if.imem_req !== 1'b1) begin errors++; $display("[TB] FAIL first_req got %0h exp 1", mem_if.imem_req); end
      checks++; if (mem_if.imem_addr !== 64'h0) begin errors++; $display("[TB] FAIL first_addr got %0h exp 0", mem_if.imem_addr); end
      mem_if.imem_ack = 1'b1;
      mem_if.imem_rdata = 32'h8B020020;
      tick();
      mem_if.imem_ack = 1'b0;
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL first_valid got %0h exp 1", instr_valid); end
      checks++; if (instr !== 32'h8B020020) begin errors++; $display("[TB] FAIL first_instr got %0h exp 8b020020", instr); end
      checks++; if (opcode !== 11'h458) begin errors++; $display("[TB] FAIL first_opcode got %0h exp 458", opcode); end
      checks++; if (pc !== 64'h0) begin errors++; $display("[TB] FAIL first_pc got %0h exp 0", pc); end
      checks++; if (mem_if.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL first_req_drop got %0h exp 0", mem_if.imem_req); end
   endtask

   task automatic test_sequential();
      logic [31:0] word;
      start_fetch();
      stall = 1'b0;
      for (int i = 0; i < 4; i++) begin
         word = 32'hF8400000 + 32'(i);
         for (int w = 0; w < 3; w++) begin
            checks++; if (mem_if.imem_req !== 1'b1) begin errors++; $display("[TB] FAIL seq_wait_req i=%0d got %0h exp 1", i, mem_if.imem_req); end
            checks++; if (mem_if.imem_addr !== 64'(4 * i)) begin errors++; $display("[TB] FAIL seq_wait_addr i=%0d got %0h exp %0h", i, mem_if.imem_addr, 4 * i); end
            tick();
         end
         mem_if.imem_ack = 1'b1;
         mem_if.imem_rdata = word;
         tick();
         mem_if.imem_ack = 1'b0;
         checks++; if (instr !== word || instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL seq_instr i=%0d got %0h/%0h exp %0h/1", i, instr, instr_valid, word); end
         checks++; if (pc !== 64'(4 * i)) begin errors++; $display("[TB] FAIL seq_pc i=%0d got %0h exp %0h", i, pc, 4 * i); end
         tick();
         checks++; if (retired !== 32'(i + 1)) begin errors++; $display("[TB] FAIL seq_retired i=%0d got %0d exp %0d", i, retired, i + 1); end
      end
      stall = 1'b1;
      checks++; if (mem_if.imem_addr !== 64'h10) begin errors++; $display("[TB] FAIL seq_final_addr got %0h exp 10", mem_if.imem_addr); end
   endtask

   task automatic test_branch();
      start_fetch();
      issue_with(1'b1, 64'h10, 32'hB4000080);
      checks++; if (mem_if.imem_addr !== 64'h40) begin errors++; $display("[TB] FAIL br_setup got %0h exp 40", mem_if.imem_addr); end
      issue_with(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 32'hB4000080);
      checks++; if (mem_if.imem_addr !== 64'h38) begin errors++; $display("[TB] FAIL br_back got %0h exp 38", mem_if.imem_addr); end
      issue_with(1'b1, 64'h2, 32'hB4000080);
      checks++; if (mem_if.imem_addr !== 64'h40) begin errors++; $display("[TB] FAIL br_return got %0h exp 40", mem_if.imem_addr); end
      issue_with(1'b1, 64'h5, 32'hB4000080);
      checks++; if (mem_if.imem_addr !== 64'h54) begin errors++; $display("[TB] FAIL br_fwd got %0h exp 54", mem_if.imem_addr); end
      issue_with(1'b1, 64'hC000_0000_0000_0001, 32'hB4000080);
      checks++; if (mem_if.imem_addr !== 64'h58) begin errors++; $display("[TB] FAIL br_topbits got %0h exp 58", mem_if.imem_addr); end
      checks++; if (retired !== 32'd5) begin errors++; $display("[TB] FAIL br_retired got %0d exp 5", retired); end
   endtask

   task automatic test_stall();
      start_fetch();
      mem_if.imem_ack = 1'b1;
      mem_if.imem_rdata = 32'h12345678;
      tick();
      for (int i = 0; i < 5; i++) begin
         mem_if.imem_ack = 1'b1;
         mem_if.imem_rdata = 32'hCAFE0000 + 32'(i);
         pc_src = i[0];
         branch_off = 64'h7;
         tick();
         checks++; if (instr !== 32'h12345678 || instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_instr c=%0d got %0h/%0h exp 12345678/1", i, instr, instr_valid); end
         checks++; if (pc !== 64'h0 || retired !== 32'd0) begin errors++; $display("[TB] FAIL stall_pc c=%0d got %0h/%0d exp 0/0", i, pc, retired); end
         checks++; if (mem_if.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_req c=%0d got %0h exp 0", i, mem_if.imem_req); end
      end
      mem_if.imem_ack = 1'b0;
      pc_src = 1'b0;
      branch_off = '0;
      stall = 1'b0;
      tick();
      checks++; if (pc !== 64'h4 || retired !== 32'd1) begin errors++; $display("[TB] FAIL stall_release got %0h/%0d exp 4/1", pc, retired); end
      checks++; if (mem_if.imem_req !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_refetch got %0h/%0h exp 1/0", mem_if.imem_req, instr_valid); end
      tick();
      checks++; if (pc !== 64'h4 || retired !== 32'd1) begin errors++; $display("[TB] FAIL stall_once got %0h/%0d exp 4/1", pc, retired); end
      stall = 1'b1;
   endtask

   task automatic test_wrap_reset();
      start_fetch();
      issue_with(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 32'hAAAA5555);
      checks++; if (pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_top got %0h exp fffffffffffffffc", pc); end
      issue_with(1'b0, 64'h0, 32'hAAAA5555);
      checks++; if (pc !== 64'h0 || mem_if.imem_addr !== 64'h0) begin errors++; $display("[TB] FAIL wrap_zero got %0h/%0h exp 0/0", pc, mem_if.imem_addr); end
      issue_with(1'b0, 64'h0, 32'hAAAA5555);
      tick();
      rst = 1'b1;
      #2;
      checks++; if (pc !== 64'h0 || retired !== 32'd0) begin errors++; $display("[TB] FAIL mid_rst_pc got %0h/%0d exp 0/0", pc, retired); end
      checks++; if (mem_if.imem_req !== 1'b0 || instr !== 32'h0 || instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_out got %0h/%0h/%0h exp 0/0/0", mem_if.imem_req, instr, instr_valid); end
      tick();
      rst = 1'b0;
      mem_if.imem_ack = 1'b1;
      mem_if.imem_rdata = 32'hDEADBEEF;
      tick();
      checks++; if (instr !== 32'h0 || instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL late_ack got %0h/%0h exp 0/0", instr, instr_valid); end
      checks++; if (mem_if.imem_req !== 1'b1 || mem_if.imem_addr !== 64'h0) begin errors++; $display("[TB] FAIL restart got %0h/%0h exp 1/0", mem_if.imem_req, mem_if.imem_addr); end
      mem_if.imem_rdata = 32'h91000421;
      tick();
      mem_if.imem_ack = 1'b0;
      checks++; if (instr !== 32'h91000421 || pc !== 64'h0) begin errors++; $display("[TB] FAIL restart_instr got %0h/%0h exp 91000421/0", instr, pc); end
   endtask

`ifdef FETCH_TIMEOUT_EN
   task automatic test_timeout();
      start_fetch();
      for (int i = 0; i < 15; i++) tick();
      checks++; if (mem_if.imem_req !== 1'b1 || fetch_err !== 1'b0) begin errors++; $display("[TB] FAIL to_before got %0h/%0h exp 1/0", mem_if.imem_req, fetch_err); end
      tick();
      checks++; if (fetch_err !== 1'b1 || mem_if.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL to_hit got %0h/%0h exp 1/0", fetch_err, mem_if.imem_req); end
      mem_if.imem_ack = 1'b1;
      mem_if.imem_rdata = 32'h11111111;
      tick();
      tick();
      mem_if.imem_ack = 1'b0;
      checks++; if (fetch_err !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL to_sticky got %0h/%0h exp 1/0", fetch_err, instr_valid); end
      start_fetch();
      checks++; if (fetch_err !== 1'b0) begin errors++; $display("[TB] FAIL to_cleared got %0h exp 0", fetch_err); end
      for (int i = 0; i < 15; i++) tick();
      mem_if.imem_ack = 1'b1;
      mem_if.imem_rdata = 32'h22222222;
      tick();
      mem_if.imem_ack = 1'b0;
      checks++; if (fetch_err !== 1'b0 || instr_valid !== 1'b1 || instr !== 32'h22222222) begin errors++; $display("[TB] FAIL to_last_ack got %0h/%0h/%0h exp 0/1/22222222", fetch_err, instr_valid, instr); end
   endtask
`else
   task automatic test_timeout();
      start_fetch();
      for (int i = 0; i < 20; i++) tick();
      checks++; if (mem_if.imem_req !== 1'b1 || fetch_err !== 1'b0) begin errors++; $display("[TB] FAIL no_timeout got %0h/%0h exp 1/0", mem_if.imem_req, fetch_err); end
      mem_if.imem_ack = 1'b1;
      mem_if.imem_rdata = 32'h33333333;
      tick();
      mem_if.imem_ack = 1'b0;
      checks++; if (instr_valid !== 1'b1 || instr !== 32'h33333333) begin errors++; $display("[TB] FAIL long_wait_ack got %0h/%0h exp 1/33333333", instr_valid, instr); end
   endtask
`endif

   // Scenario sequence.
   initial begin
      test_reset();
      test_sequential();
      test_branch();
      test_stall();
      test_wrap_reset();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
